cdr_phase_ctrl: RTL
===================

Name: cdr_phase_ctrl

Overview:
Phase-tracking controller for the ZigBee receiver's CDR.
- Consumes the per-chip decision strobe and early/late votes from the timing error detector.
- Filters the votes and issues one-cycle advance or slip commands to the decision counter, which moves the decision instant by one sample.
- Latches the samples-per-chip configuration and runs an acquisition/tracking/loss-of-lock state machine that drives the receiver lock flag.

Parameters:
- ACC_W, 5: signed loop-filter accumulator width; saturates at ±(2^(ACC_W-1)-1).
- ACQ_THR, 2: correction threshold |acc| in ACQ.
- TRK_THR, 8: correction threshold |acc| in TRACK; must be ≤ 2^(ACC_W-1)-1.
- LOCK_CNT, 16: consecutive uncorrected decisions needed to declare lock.
- LOSS_WIN, 32: decisions per loss-monitor window in TRACK.
- LOSS_MAX, 4: corrections within one window that declare loss of lock.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_en  in  1  receiver enable; low forces IDLE
- i_nb_P  in  6  samples per chip; latched on IDLE->ACQ
- i_en_dec  in  1  decision strobe, one cycle per chip
- i_early  in  1  early vote, valid only with i_en_dec
- i_late  in  1  late vote, valid only with i_en_dec
- o_nb_P  out  6  latched samples-per-chip config to the decision counter
- o_adv  out  1  one-cycle pulse: shorten the current chip period by one sample
- o_slip  out  1  one-cycle pulse: lengthen the current chip period by one sample
- o_lock  out  1  CDR locked
- o_state  out  2  0=IDLE, 1=ACQ, 2=TRACK
- o_cfg_err  out  1  sticky: enable seen with i_nb_P < 2

Behaviour:
Clock and reset are fixed: one clock (i_clk); i_rst is asynchronous, active-high.

Reset: all outputs 0, o_nb_P=0, state IDLE, accumulator and all counters 0.

IDLE:
- When i_en=1 and i_nb_P ≥ 2: latch i_nb_P into o_nb_P, go to ACQ next cycle.
- When i_en=1 and i_nb_P < 2: stay in IDLE, set o_cfg_err. o_cfg_err clears only on reset or on a valid entry to ACQ.

i_en=0 in any state: next cycle go to IDLE, clear accumulator and counters, o_lock=0, no pulse issued. o_nb_P is held.

i_nb_P changes outside IDLE are ignored.

Loop filter, updated only on cycles with i_en_dec=1:
- Step: +1 if early only, -1 if late only, 0 if neither or both.
- Saturating add: acc_next = sat(acc + step).
- If acc_next ≥ THR: o_adv=1 the following cycle, acc cleared.
- If acc_next ≤ -THR: o_slip=1 the following cycle, acc cleared.
- Otherwise acc=acc_next.
- THR is ACQ_THR in ACQ and TRK_THR in TRACK.
- Latency is exactly 1 cycle from i_en_dec to pulse. o_adv and o_slip are never asserted together.

ACQ:
- lock_cnt increments on each uncorrected decision and clears on a corrected one.
- When it reaches LOCK_CNT: go to TRACK, set o_lock=1, clear acc, win_cnt and corr_cnt.
- A decision that both corrects and would reach LOCK_CNT does not lock, because the correction clears lock_cnt.

TRACK:
- win_cnt counts decisions; corr_cnt counts corrections.
- When win_cnt reaches LOSS_WIN, evaluate corr_cnt including the current decision:
  - corr_cnt ≥ LOSS_MAX: go to ACQ, o_lock=0, clear acc and lock_cnt.
  - Otherwise: clear both counters and stay in TRACK.
- A correction issued on the transition decision is still pulsed.

Counter widths: lock_cnt, win_cnt and corr_cnt are sized with $clog2 of their limit plus 1. No wrap before the terminal compare.

Optional Feature:
CDR_STATS_EN
- Defined: adds outputs o_adv_cnt[15:0] and o_slip_cnt[15:0], saturating counts of issued pulses. They clear on reset and on entry to ACQ from IDLE.
- Undefined: those ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package cdr_pkg:
  - state enum cdr_state_t {IDLE, ACQ, TRACK}
  - NB_P_W=6
  - NB_P_MIN=2
  - shared with the decision counter and other CDR blocks
- Sub-module cdr_loop_filter: signed saturating accumulator plus threshold compare, with clear input. It outputs adv_req and slip_req; all sequencing stays in the top.

Test Plan:
- Reset mid-ACQ (acc=1, lock_cnt=5): assert i_rst asynchronously -> all outputs 0 immediately, state IDLE.
- i_en=1, i_nb_P=8, two early-only strobes -> state ACQ, o_nb_P=8, o_adv pulse exactly 1 cycle after the 2nd strobe, acc back to 0.
- ACQ with 16 strobes, no votes -> o_lock=1 and o_state=2 after the 16th. Repeat with a late/late slip at strobe 15 -> lock only after 16 further clean strobes.
- TRACK, window of 32 strobes with 4×8 late votes -> 4 o_slip pulses, then ACQ and o_lock=0 at strobe 32. Same with 3 corrections -> stays in TRACK.
- i_nb_P=1 with i_en=1 -> stays in IDLE, o_cfg_err=1. Then i_nb_P=4 -> ACQ, o_cfg_err=0.
- Early and late both high on every strobe, and i_en dropped in TRACK -> no pulses, acc stays 0; IDLE the next cycle, o_lock=0.

Source files
------------

// File: rtl/cdr_pkg.sv
// -----------------------------------------------------------------------------
// cdr_pkg
// Shared definitions for the ZigBee receiver CDR blocks (phase controller,
// decision counter and friends).
//   cdr_state_t : controller state encoding, also exported on o_state
//   NB_P_W      : width of the samples-per-chip configuration
//   NB_P_MIN    : smallest samples-per-chip value the decision counter supports
// -----------------------------------------------------------------------------
package cdr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } cdr_state_t;

    localparam int NB_P_W   = 6;
    localparam int NB_P_MIN = 2;

endpackage

// File: rtl/cdr_loop_filter.sv
// -----------------------------------------------------------------------------
// cdr_loop_filter
// Signed saturating early/late accumulator with threshold compare.
// The accumulator moves only on decision cycles; when the updated value
// reaches +thr or -thr a correction request is raised in the same cycle
// and the accumulator restarts from zero.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clr          clear accumulator (wins over a decision in the same cycle)
//   i_thr          current correction threshold (positive, unsigned)
//   i_dec          decision strobe (already qualified by the controller)
//   i_early/i_late early/late votes, meaningful only with i_dec
//   o_adv_req      combinational: advance requested by this decision
//   o_slip_req     combinational: slip requested by this decision
// -----------------------------------------------------------------------------
module cdr_loop_filter #(
    parameter int ACC_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [ACC_W-1:0] i_thr,
    input  logic             i_dec,
    input  logic             i_early,
    input  logic             i_late,
    output logic             o_adv_req,
    output logic             o_slip_req
);

    localparam int ACC_MAX_I = (1 << (ACC_W - 1)) - 1;
    localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W + 1)'(ACC_MAX_I);
    localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

    // Symmetric saturation: the most negative code is never used so that
    // +/- thresholds behave identically.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > ACC_MAX)
            r = ACC_MAX[ACC_W-1:0];
        else if (v < ACC_MIN)
            r = ACC_MIN[ACC_W-1:0];
        else
            r = v[ACC_W-1:0];
        return r;
    endfunction

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W:0]   step;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   acc_nxt_x;
    logic signed [ACC_W:0]   thr_s;

    always_comb begin
        step = '0;
        if (i_early && !i_late)
            step = (ACC_W + 1)'(1);
        else if (i_late && !i_early)
            step = {(ACC_W + 1){1'b1}};
        sum       = {acc_q[ACC_W-1], acc_q} + step;
        acc_nxt   = sat(sum);
        acc_nxt_x = {acc_nxt[ACC_W-1], acc_nxt};
        thr_s     = {1'b0, i_thr};
        o_adv_req  = i_dec && (acc_nxt_x >= thr_s);
        o_slip_req = i_dec && (acc_nxt_x <= -thr_s);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            acc_q <= '0;
        else if (i_clr)
            acc_q <= '0;
        else if (i_dec)
            acc_q <= (o_adv_req || o_slip_req) ? '0 : acc_nxt;
    end

endmodule

// File: rtl/cdr_phase_ctrl.sv
// -----------------------------------------------------------------------------
// cdr_phase_ctrl
// Phase-tracking controller for the ZigBee receiver CDR. Filters early/late
// votes from the timing error detector and issues one-cycle advance/slip
// commands to the decision counter; runs the IDLE/ACQ/TRACK lock FSM.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_en          receiver enable; low returns to IDLE
//   i_nb_P        samples per chip, latched on IDLE->ACQ
//   i_en_dec      decision strobe (one cycle per chip)
//   i_early/i_late votes, valid only with i_en_dec
//   o_nb_P        latched samples-per-chip
//   o_adv/o_slip  one-cycle correction pulses, one cycle after the strobe
//   o_lock        locked (TRACK state)
//   o_state       0=IDLE 1=ACQ 2=TRACK
//   o_cfg_err     sticky: enable seen with i_nb_P < NB_P_MIN
// Build option CDR_STATS_EN adds o_adv_cnt/o_slip_cnt, saturating counts of
// issued pulses, cleared on reset and on IDLE->ACQ.
// -----------------------------------------------------------------------------
module cdr_phase_ctrl
    import cdr_pkg::*;
#(
    parameter int ACC_W    = 5,
    parameter int ACQ_THR  = 2,
    parameter int TRK_THR  = 8,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_WIN = 32,
    parameter int LOSS_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [NB_P_W-1:0] i_nb_P,
    input  logic              i_en_dec,
    input  logic              i_early,
    input  logic              i_late,
    output logic [NB_P_W-1:0] o_nb_P,
    output logic              o_adv,
    output logic              o_slip,
    output logic              o_lock,
    output logic [1:0]        o_state,
    output logic              o_cfg_err
`ifdef CDR_STATS_EN
    ,
    output logic [15:0]       o_adv_cnt,
    output logic [15:0]       o_slip_cnt
`endif
);

    localparam int LOCK_W = $clog2(LOCK_CNT) + 1;
    localparam int WIN_W  = $clog2(LOSS_WIN) + 1;
    localparam int CORR_W = $clog2(LOSS_MAX) + 1;

    cdr_state_t        state_q, state_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d, win_inc;
    logic [CORR_W-1:0] corr_cnt_q, corr_cnt_d, corr_inc;
    logic [NB_P_W-1:0] nb_p_q;
    logic              cfg_err_q, cfg_err_d;
    logic              nb_load;
    logic              filt_clr;
    logic              dec;
    logic              corr;
    logic              adv_req, slip_req;
    logic              adv_p1, slip_p1;
    logic [ACC_W-1:0]  thr_sel;

    // Votes count only while the loop is running and enabled.
    assign dec     = i_en && i_en_dec && ((state_q == ACQ) || (state_q == TRACK));
    assign corr    = adv_req || slip_req;
    assign thr_sel = (state_q == TRACK) ? ACC_W'(TRK_THR) : ACC_W'(ACQ_THR);

    cdr_loop_filter #(
        .ACC_W (ACC_W)
    ) u_filt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (filt_clr),
        .i_thr      (thr_sel),
        .i_dec      (dec),
        .i_early    (i_early),
        .i_late     (i_late),
        .o_adv_req  (adv_req),
        .o_slip_req (slip_req)
    );

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        win_cnt_d  = win_cnt_q;
        corr_cnt_d = corr_cnt_q;
        cfg_err_d  = cfg_err_q;
        nb_load    = 1'b0;
        filt_clr   = 1'b0;
        lock_inc   = lock_cnt_q + LOCK_W'(1);
        win_inc    = win_cnt_q + WIN_W'(1);
        // corr_cnt stops at LOSS_MAX so a narrow counter never wraps.
        corr_inc   = (corr_cnt_q >= CORR_W'(LOSS_MAX)) ? corr_cnt_q
                                                        : corr_cnt_q + CORR_W'(corr);

        if (!i_en) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
            win_cnt_d  = '0;
            corr_cnt_d = '0;
            filt_clr   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    lock_cnt_d = '0;
                    win_cnt_d  = '0;
                    corr_cnt_d = '0;
                    filt_clr   = 1'b1;
                    if (i_nb_P >= NB_P_W'(NB_P_MIN)) begin
                        state_d   = ACQ;
                        nb_load   = 1'b1;
                        cfg_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                ACQ: begin
                    if (dec) begin
                        // A correcting decision restarts the count, so it can never lock.
                        if (corr) begin
                            lock_cnt_d = '0;
                        end else if (lock_inc == LOCK_W'(LOCK_CNT)) begin
                            state_d    = TRACK;
                            lock_cnt_d = '0;
                            win_cnt_d  = '0;
                            corr_cnt_d = '0;
                            filt_clr   = 1'b1;
                        end else begin
                            lock_cnt_d = lock_inc;
                        end
                    end
                end
                TRACK: begin
                    if (dec) begin
                        if (win_inc == WIN_W'(LOSS_WIN)) begin
                            win_cnt_d  = '0;
                            corr_cnt_d = '0;
                            if (corr_inc >= CORR_W'(LOSS_MAX)) begin
                                state_d    = ACQ;
                                lock_cnt_d = '0;
                                filt_clr   = 1'b1;
                            end
                        end else begin
                            win_cnt_d  = win_inc;
                            corr_cnt_d = corr_inc;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    filt_clr = 1'b1;
                end
            endcase
        end
    end

    // ---- stage p1: registered state and correction pulses ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            win_cnt_q  <= '0;
            corr_cnt_q <= '0;
            nb_p_q     <= '0;
            cfg_err_q  <= 1'b0;
            adv_p1     <= 1'b0;
            slip_p1    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            win_cnt_q  <= win_cnt_d;
            corr_cnt_q <= corr_cnt_d;
            cfg_err_q  <= cfg_err_d;
            adv_p1     <= adv_req;
            slip_p1    <= slip_req;
            if (nb_load)
                nb_p_q <= i_nb_P;
        end
    end

    assign o_nb_P    = nb_p_q;
    assign o_adv     = adv_p1;
    assign o_slip    = slip_p1;
    assign o_lock    = (state_q == TRACK);
    assign o_state   = state_q;
    assign o_cfg_err = cfg_err_q;

`ifdef CDR_STATS_EN
    logic [15:0] adv_cnt_q, slip_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            adv_cnt_q  <= '0;
            slip_cnt_q <= '0;
        end else if (nb_load) begin
            adv_cnt_q  <= '0;
            slip_cnt_q <= '0;
        end else begin
            if (adv_req && (adv_cnt_q != 16'hFFFF))
                adv_cnt_q <= adv_cnt_q + 16'd1;
            if (slip_req && (slip_cnt_q != 16'hFFFF))
                slip_cnt_q <= slip_cnt_q + 16'd1;
        end
    end

    assign o_adv_cnt  = adv_cnt_q;
    assign o_slip_cnt = slip_cnt_q;
`endif

endmodule
